ysyx_25060170_lsu: RTL
======================

# ysyx_25060170_lsu

Multi-cycle load/store unit between the EXU and the WBU. It takes one memory operation at a time: the EXU-computed address, store data from rs2, access size and signedness. It performs the access over a valid/ready memory bus with word-aligned addresses and byte strobes. It returns aligned, sign- or zero-extended load data (or store completion) to the WBU through a valid/ready handshake, which replaces combinational memory access in the write-back path.

## Interface
- Parameters: none; all widths fixed at 32-bit address/data.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: EXU presents a memory op.
- `in_ready` out 1: LSU can accept; high only in IDLE.
- `in_addr` in 32: byte address (EXU result).
- `in_wdata` in 32: store data (rs2), low bytes significant.
- `in_load` in 1: op is a load.
- `in_store` in 1: op is a store.
- `in_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `in_unsigned` in 1: zero-extend load data (lbu/lhu).
- `mem_req_valid` out 1: bus request pending.
- `mem_req_ready` in 1: bus accepts request.
- `mem_req_we` out 1: 1 = write.
- `mem_req_addr` out 32: `{in_addr[31:2], 2'b00}`.
- `mem_req_wdata` out 32: store data shifted to its byte lane.
- `mem_req_wstrb` out 4: byte enables; 0 for reads.
- `mem_rsp_valid` in 1: bus response.
- `mem_rsp_ready` out 1: high only in WAIT.
- `mem_rsp_rdata` in 32: read word.
- `mem_rsp_err` in 1: bus error.
- `out_valid` out 1: result available to WBU.
- `out_ready` in 1: WBU consumes result.
- `out_rdata` out 32: extended load data; 0 for stores/errors.
- `out_err` out 1: misaligned, illegal size, or bus error.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, the unit latches the address, data, size, unsigned and kind, then chooses the next state:
  - If neither load nor store: DONE with rdata=0, err=0.
  - If size=11, or halfword with addr[0]≠0, or word with addr[1:0]≠0: DONE with err=1, rdata=0. No bus activity.
  - If both `in_load` and `in_store` are set: the op is treated as a load.
  - Otherwise: REQ.
- REQ: `mem_req_valid`=1 with stable addr/we/wdata/wstrb. On `mem_req_ready`, go to WAIT.
- WAIT: `mem_rsp_ready`=1. On `mem_rsp_valid`:
  - Latch the result: loads take `mem_rsp_rdata`; stores get 0.
  - Latch `err` = `mem_rsp_err`.
  - Go to DONE.
- DONE: `out_valid`=1, and `out_rdata`/`out_err` are held stable. On `out_ready`, go to IDLE. No new request is accepted in the same cycle.
- Store lanes, with o = addr[1:0]:
  - wdata = `in_wdata << (8*o)`.
  - wstrb = byte `4'b0001<<o`, half `4'b0011<<o`, word `4'b1111`.
- Load extract: s = `mem_rsp_rdata >> (8*o)`. Byte uses s[7:0]; half uses s[15:0]. The result is sign-extended unless `in_unsigned`. Word is returned unchanged.
- Load with bus error: rdata=0, err=1.

## Timing
- Reset: state IDLE. Registered outputs after reset:
  - `in_ready`=1.
  - `mem_req_valid`=0, `mem_req_we`=0, `mem_req_addr`=0, `mem_req_wdata`=0, `mem_req_wstrb`=0.
  - `mem_rsp_ready`=0.
  - `out_valid`=0, `out_rdata`=0, `out_err`=0.
- Reset mid-operation (any state): next cycle is IDLE.
  - Any pending request is dropped.
  - A later `mem_rsp_valid` is ignored because `mem_rsp_ready`=0.
  - Any undelivered result is discarded.
- Accept in cycle 0 → `mem_req_valid` in cycle 1.
- With ready in cycle 1 and response in cycle 2 → `out_valid` in cycle 3.
- Minimum memory op latency: 3 cycles from accept to `out_valid`.
- Faulting or no-op request: `out_valid` in cycle 1.
- Throughput: one op per 4 cycles minimum, since DONE→IDLE costs one cycle.
- Backpressure: REQ and DONE may stall indefinitely. All outputs hold stable while stalled.
- `mem_rsp_valid` outside WAIT is ignored.

## Test plan
- lb, addr 0x80000003, mem word 0x80AABBCC → `mem_req_addr`=0x80000000, wstrb=0, `out_rdata`=0xFFFFFF80, err=0, `out_valid` 3 cycles after accept.
- sh, addr 0x80000002, wdata 0x1234ABCD → wdata=0xABCD0000, wstrb=4'b1100, we=1; `out_rdata`=0.
- lw, addr 0x80000006 → no `mem_req_valid` ever; `out_valid` next cycle with err=1, rdata=0.
- lhu, addr 0x80000002, word 0xF00D0000, `mem_req_ready` low 5 cycles and `out_ready` low 3 cycles → `out_rdata`=0x0000F00D. Request and result are held stable throughout; `in_ready` stays 0 until the DONE handshake.
- `rst` asserted in WAIT, then `mem_rsp_valid` pulsed → IDLE, `out_valid` never rises, `in_ready`=1 one cycle after reset.
- lw with `mem_rsp_err`=1 → `out_err`=1, `out_rdata`=0.

Source files
------------

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU: one op in flight, word-aligned bus with byte strobes.
// Memory ops take >= 3 cycles accept-to-result, faults/no-ops 1 cycle; REQ and DONE stall on bus/WBU ready.
module ysyx_25060170_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_rsp_valid,
   output logic        mem_rsp_ready,
   input  logic [31:0] mem_rsp_rdata,
   input  logic        mem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   logic        r_in_ready;
   logic        r_req_valid;
   logic        r_req_we;
   logic [31:0] r_req_addr;
   logic [31:0] r_req_wdata;
   logic [3:0]  r_req_wstrb;
   logic        r_rsp_ready;
   logic        r_out_valid;
   logic [31:0] r_out_rdata;
   logic        r_out_err;
   logic        r_load;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;

   logic        w_is_mem;
   logic        w_fault;
   logic [3:0]  w_strb;

   assign w_is_mem = in_load | in_store;
   assign w_fault  = (in_size == 2'b11) ||
                     (in_size == 2'b01 && in_addr[0]) ||
                     (in_size == 2'b10 && in_addr[1:0] != 2'b00);

   always_comb begin
      w_strb = 4'b1111;
      case (in_size)
         2'b00:   w_strb = 4'b0001 << in_addr[1:0];
         2'b01:   w_strb = 4'b0011 << in_addr[1:0];
         default: w_strb = 4'b1111;
      endcase
   end

   function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] o,
                                             input logic [1:0] sz, input logic uns);
      logic [31:0] s;
      s = w >> {o, 3'b000};
      case (sz)
         2'b00:   return uns ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         2'b01:   return uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: return w;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_req_valid <= 1'b0;
         r_req_we    <= 1'b0;
         r_req_addr  <= '0;
         r_req_wdata <= '0;
         r_req_wstrb <= '0;
         r_rsp_ready <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_rdata <= '0;
         r_out_err   <= 1'b0;
         r_load      <= 1'b0;
         r_off       <= '0;
         r_size      <= '0;
         r_unsigned  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_in_ready <= 1'b0;
               r_load     <= in_load;
               r_off      <= in_addr[1:0];
               r_size     <= in_size;
               r_unsigned <= in_unsigned;
               if (!w_is_mem || w_fault) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_out_rdata <= '0;
                  r_out_err   <= w_is_mem;
               end else begin
                  // load wins when both kinds are flagged
                  r_state     <= S_REQ;
                  r_req_valid <= 1'b1;
                  r_req_we    <= !in_load;
                  r_req_addr  <= {in_addr[31:2], 2'b00};
                  r_req_wdata <= in_load ? 32'h0 : (in_wdata << {in_addr[1:0], 3'b000});
                  r_req_wstrb <= in_load ? 4'b0000 : w_strb;
               end
            end
            S_REQ: if (mem_req_ready) begin
               r_state     <= S_WAIT;
               r_req_valid <= 1'b0;
               r_rsp_ready <= 1'b1;
            end
            S_WAIT: if (mem_rsp_valid) begin
               r_state     <= S_DONE;
               r_rsp_ready <= 1'b0;
               r_out_valid <= 1'b1;
               r_out_err   <= mem_rsp_err;
               r_out_rdata <= (r_load && !mem_rsp_err) ?
                              f_extract(mem_rsp_rdata, r_off, r_size, r_unsigned) : 32'h0;
            end
            S_DONE: if (out_ready) begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign mem_req_valid = r_req_valid;
   assign mem_req_we    = r_req_we;
   assign mem_req_addr  = r_req_addr;
   assign mem_req_wdata = r_req_wdata;
   assign mem_req_wstrb = r_req_wstrb;
   assign mem_rsp_ready = r_rsp_ready;
   assign out_valid     = r_out_valid;
   assign out_rdata     = r_out_rdata;
   assign out_err       = r_out_err;

endmodule
